// File: rtl/sha256_core_sched.sv
// sha256_core_sched: hands engine threads and free sha256 cores out in
// round-robin pairs. One block load is in flight at a time. The core's start
// is pulsed once the load completes, and the owning thread is recorded per
// core so that core outputs can be tagged with their thread.
module sha256_core_sched #(
    parameter int N_CORES       = 3,
    parameter int CORE_MSB      = 1,
    parameter int N_THREADS_MSB = 2,
    parameter int LOAD_TIMEOUT  = 63
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic [(1<<(N_THREADS_MSB+1))-1:0] thread_req,
    output logic                              thread_ack,
    output logic                              grant_valid,
    output logic [N_THREADS_MSB:0]            grant_thread,
    output logic [CORE_MSB:0]                 grant_core,
    input  logic                              load_done,
    input  logic [N_CORES-1:0]                core_ready,
    output logic [N_CORES-1:0]                core_start,
    input  logic [N_CORES-1:0]                core_dout_en,
    output logic [N_THREADS_MSB:0]            dout_thread,
    output logic                              load_err
);
    localparam int N_THREADS = 1 << (N_THREADS_MSB + 1);
    localparam int CNT_W     = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                             state_q;
    logic                               ack_q, gvld_q, err_q;
    logic [N_THREADS_MSB:0]             gthr_q;
    logic [CORE_MSB:0]                  gcore_q;
    logic [N_CORES-1:0]                 start_q, reserved_q, started_q;
    logic [N_CORES-1:0][N_THREADS_MSB:0] owner_q;
    logic [N_THREADS_MSB:0]             tptr_q, tptr_d;
    logic [CORE_MSB:0]                  cptr_q, cptr_d;
    logic [CNT_W-1:0]                   cnt_q;

    logic [N_CORES-1:0]                 free;
    logic                               thr_vld, core_vld;
    logic [N_THREADS_MSB:0]             pick_thr, t_idx;
    logic [CORE_MSB:0]                  pick_core;
    logic [CORE_MSB+1:0]                c_sum;

    assign thread_ack   = ack_q;
    assign grant_valid  = gvld_q;
    assign grant_thread = gthr_q;
    assign grant_core   = gcore_q;
    assign core_start   = start_q;
    assign load_err     = err_q;

    // Round-robin pick: lowest offset from each pointer wins, so scan downwards
    always_comb begin
        free      = core_ready & ~reserved_q;
        thr_vld   = 1'b0;
        pick_thr  = tptr_q;
        t_idx     = tptr_q;
        core_vld  = 1'b0;
        pick_core = cptr_q;
        c_sum     = '0;
        for (int k = N_THREADS - 1; k >= 0; k--) begin
            t_idx = tptr_q + (N_THREADS_MSB+1)'(k);
            if (thread_req[t_idx]) begin
                thr_vld  = 1'b1;
                pick_thr = t_idx;
            end
        end
        for (int k = N_CORES - 1; k >= 0; k--) begin
            c_sum = {1'b0, cptr_q} + (CORE_MSB+2)'(k);
            if (c_sum >= (CORE_MSB+2)'(N_CORES))
                c_sum = c_sum - (CORE_MSB+2)'(N_CORES);
            if (free[c_sum[CORE_MSB:0]]) begin
                core_vld  = 1'b1;
                pick_core = c_sum[CORE_MSB:0];
            end
        end
        tptr_d = pick_thr + 1'b1;
        cptr_d = (pick_core == (CORE_MSB+1)'(N_CORES - 1)) ? '0 : pick_core + 1'b1;
    end

    // Scheduler FSM: arbitration, grant hold, load timeout, reservation tracking
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            gvld_q     <= 1'b0;
            err_q      <= 1'b0;
            gthr_q     <= '0;
            gcore_q    <= '0;
            start_q    <= '0;
            reserved_q <= '0;
            started_q  <= '0;
            owner_q    <= '0;
            tptr_q     <= '0;
            cptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            ack_q   <= 1'b0;
            start_q <= '0;
            // A started core drops ready once it has latched the block; it is then its own
            for (int i = 0; i < N_CORES; i++) begin
                if (started_q[i] && !start_q[i] && !core_ready[i]) begin
                    reserved_q[i] <= 1'b0;
                    started_q[i]  <= 1'b0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (thr_vld && core_vld) begin
                        gthr_q                <= pick_thr;
                        gcore_q               <= pick_core;
                        reserved_q[pick_core] <= 1'b1;
                        owner_q[pick_core]    <= pick_thr;
                        ack_q                 <= 1'b1;
                        gvld_q                <= 1'b1;
                        cnt_q                 <= '0;
                        tptr_q                <= tptr_d;
                        cptr_q                <= cptr_d;
                        state_q               <= GRANT;
                    end
                end
                GRANT: begin
                    if (load_done) begin
                        gvld_q             <= 1'b0;
                        start_q[gcore_q]   <= 1'b1;
                        started_q[gcore_q] <= 1'b1;
                        state_q            <= IDLE;
                    end else if (cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
                        // Engine never finished: abandon the core without starting it
                        gvld_q              <= 1'b0;
                        err_q               <= 1'b1;
                        reserved_q[gcore_q] <= 1'b0;
                        state_q             <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output tag: owner of the lowest-index core presenting a digest
    always_comb begin
        dout_thread = '0;
        for (int i = N_CORES - 1; i >= 0; i--)
            if (core_dout_en[i]) dout_thread = owner_q[i];
    end

endmodule

// File: tb/tb_sha256_core_sched.sv
`timescale 1ns/1ps
module tb_sha256_core_sched;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] thread_req;
    logic       thread_ack, grant_valid, load_done, load_err;
    logic [2:0] grant_thread, dout_thread;
    logic [1:0] grant_core;
    logic [2:0] core_ready, core_start, core_dout_en;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { logic [2:0] thr; logic [1:0] core; } exp_t;
    typedef struct { logic [7:0] req; logic [2:0] rdy; int dly; logic [2:0] et; logic [1:0] ec; } vec_t;
    exp_t sb[$];
    vec_t tbl[9];

    sha256_core_sched #(.N_CORES(3), .CORE_MSB(1), .N_THREADS_MSB(2), .LOAD_TIMEOUT(63)) dut (
        .CLK(CLK), .RST_N(RST_N), .thread_req(thread_req), .thread_ack(thread_ack),
        .grant_valid(grant_valid), .grant_thread(grant_thread), .grant_core(grant_core),
        .load_done(load_done), .core_ready(core_ready), .core_start(core_start),
        .core_dout_en(core_dout_en), .dout_thread(dout_thread), .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        thread_req = '0;
        load_done = 1'b0;
        core_dout_en = '0;
        #2;
        check("rst_ack", thread_ack, 0);
        check("rst_gvalid", grant_valid, 0);
        check("rst_gthread", grant_thread, 0);
        check("rst_gcore", grant_core, 0);
        check("rst_start", core_start, 0);
        check("rst_err", load_err, 0);
        step();
        RST_N = 1'b1;
        step();
    endtask

    // Drive a request, expect the grant to arrive within a bounded wait
    task automatic req_grant(input logic [7:0] req, input logic [2:0] et, input logic [1:0] ec);
        exp_t e;
        bit got;
        e.thr = et;
        e.core = ec;
        sb.push_back(e);
        thread_req = req;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (thread_ack) got = 1;
        end
        thread_req = '0;
        e = sb.pop_front();
        check("ack_seen", 32'(got), 1);
        if (got) begin
            check("grant_thread", grant_thread, e.thr);
            check("grant_core", grant_core, e.core);
            check("grant_valid", grant_valid, 1);
        end
    endtask

    // Called in grant cycle 1; load_done lands in grant cycle 'dly'
    task automatic finish_load(input int dly, input logic [1:0] ec);
        bit bad;
        bad = 0;
        for (int i = 1; i < dly; i++) begin
            step();
            if (!grant_valid || thread_ack || core_start != 0) bad = 1;
        end
        check("hold_grant", 32'(bad), 0);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("core_start", core_start, 32'(1) << ec);
        check("gvalid_drop", grant_valid, 0);
        step();
        check("start_one_cycle", core_start, 0);
    endtask

    // Model a core latching its start: ready low for one cycle
    task automatic core_take(input int c);
        core_ready[c] = 1'b0;
        step();
        core_ready[c] = 1'b1;
    endtask

    initial begin
        bit bad;
        thread_req = '0;
        load_done = 1'b0;
        core_ready = 3'b111;
        core_dout_en = '0;

        tbl[0] = '{8'hFF, 3'b111, 1, 3'd0, 2'd0};
        tbl[1] = '{8'hFF, 3'b111, 1, 3'd1, 2'd1};
        tbl[2] = '{8'hFF, 3'b111, 1, 3'd2, 2'd2};
        tbl[3] = '{8'hFF, 3'b111, 1, 3'd3, 2'd0};
        tbl[4] = '{8'hFF, 3'b111, 1, 3'd4, 2'd1};
        tbl[5] = '{8'hFF, 3'b111, 1, 3'd5, 2'd2};
        tbl[6] = '{8'hFF, 3'b111, 1, 3'd6, 2'd0};
        tbl[7] = '{8'hFF, 3'b111, 1, 3'd7, 2'd1};
        tbl[8] = '{8'hFF, 3'b111, 1, 3'd0, 2'd2};

        // Single request, then reuse of the same core once it has taken its start
        do_reset();
        req_grant(8'b0000_0100, 3'd2, 2'd0);
        finish_load(3, 2'd0);
        core_take(0);
        core_dout_en = 3'b001;
        #1 check("dout_single", dout_thread, 2);
        core_dout_en = 3'b000;
        core_ready = 3'b001;
        req_grant(8'b0000_0100, 3'd2, 2'd0);
        finish_load(1, 2'd0);
        core_take(0);
        core_ready = 3'b111;

        // Fairness table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            core_ready = tbl[i].rdy;
            req_grant(tbl[i].req, tbl[i].et, tbl[i].ec);
            finish_load(tbl[i].dly, tbl[i].ec);
            core_take(int'(tbl[i].ec));
        end

        // Core exhaustion: core 1 stays reserved until another core appears
        do_reset();
        core_ready = 3'b010;
        req_grant(8'h01, 3'd0, 2'd1);
        finish_load(1, 2'd1);
        thread_req = 8'h02;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (thread_ack || grant_valid) bad = 1;
        end
        check("no_grant_exhausted", 32'(bad), 0);
        core_ready = 3'b110;
        req_grant(8'h02, 3'd1, 2'd2);
        finish_load(1, 2'd2);

        // load_done in the last legal cycle wins
        do_reset();
        core_ready = 3'b111;
        req_grant(8'h08, 3'd3, 2'd0);
        for (int i = 1; i < 63; i++) step();
        check("gvalid_cyc63", grant_valid, 1);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("start_at_63", core_start, 3'b001);
        check("no_err_at_63", load_err, 0);
        step();
        core_take(0);

        // Timeout: no start, sticky error, core freed
        req_grant(8'h08, 3'd3, 2'd1);
        bad = 0;
        for (int i = 1; i < 63; i++) begin
            step();
            if (core_start != 0 || load_err) bad = 1;
        end
        check("pre_timeout_quiet", 32'(bad), 0);
        check("gvalid_before_to", grant_valid, 1);
        step();
        check("timeout_err", load_err, 1);
        check("timeout_gvalid", grant_valid, 0);
        check("timeout_nostart", core_start, 0);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("idle_load_ignored", core_start, 0);
        step();
        check("idle_load_ignored2", core_start, 0);
        core_ready = 3'b010;
        req_grant(8'h08, 3'd3, 2'd1);
        finish_load(1, 2'd1);
        check("err_sticky", load_err, 1);

        // Output tagging
        do_reset();
        core_ready = 3'b111;
        req_grant(8'h20, 3'd5, 2'd0);
        finish_load(2, 2'd0);
        core_take(0);
        req_grant(8'h08, 3'd3, 2'd1);
        finish_load(1, 2'd1);
        core_take(1);
        core_dout_en = 3'b010;
        #1 check("dout_010", dout_thread, 3);
        core_dout_en = 3'b011;
        #1 check("dout_011", dout_thread, 5);
        core_dout_en = 3'b000;
        #1 check("dout_none", dout_thread, 0);
        core_dout_en = 3'b100;
        #1 check("dout_100", dout_thread, 0);
        core_dout_en = 3'b000;

        // Reset in the middle of a grant
        core_ready = 3'b011;
        req_grant(8'h02, 3'd1, 2'd0);
        RST_N = 1'b0;
        #2;
        check("mid_rst_gvalid", grant_valid, 0);
        check("mid_rst_ack", thread_ack, 0);
        check("mid_rst_start", core_start, 0);
        check("mid_rst_gthread", grant_thread, 0);
        core_dout_en = 3'b011;
        #1 check("mid_rst_owner", dout_thread, 0);
        core_dout_en = 3'b000;
        step();
        RST_N = 1'b1;
        core_ready = 3'b111;
        step();
        req_grant(8'hFF, 3'd0, 2'd0);
        finish_load(1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_core_sched.md
Name: sha256_core_sched

Overview:
- Schedules engine threads onto the shared pool of sha256core instances.
- Picks a requesting thread round-robin and a free core round-robin, then grants the pair to the engine for block load.
- Pulses that core's start once loading completes and records core ownership so the engine can tag each core's output with the owning thread.
- Sits between the engine's thread/state logic and the core array.

Parameters:
N_CORES, 3, number of sha256core instances
CORE_MSB, 1, MSB of core index (clog2(N_CORES)-1, min 0)
N_THREADS_MSB, 2, MSB of thread number; N_THREADS = 2**(N_THREADS_MSB+1)
LOAD_TIMEOUT, 63, max cycles from grant to load_done before abort

Ports:
CLK  in  1  clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
thread_req  in  N_THREADS  level request per thread, held until thread_ack
thread_ack  out  1  1-cycle pulse, granted thread's request accepted
grant_valid  out  1  high while engine may write the granted core
grant_thread  out  N_THREADS_MSB+1  thread owning current grant
grant_core  out  CORE_MSB+1  core index engine must write
load_done  in  1  1-cycle pulse, engine finished writing block to grant_core
core_ready  in  N_CORES  per-core ready from sha256core
core_start  out  N_CORES  one-hot 1-cycle start pulse
core_dout_en  in  N_CORES  per-core output valid
dout_thread  out  N_THREADS_MSB+1  owner of lowest-index core with dout_en high, combinational from owner table
load_err  out  1  sticky, set on load timeout, cleared only by reset

Behaviour:
- Reset (async, RST_N low): state IDLE; thread_ack=0, grant_valid=0, grant_thread=0, grant_core=0, core_start=0, load_err=0, reserved=0, owner table=0, thread RR pointer=0, core RR pointer=0, timeout counter=0. Reset mid-grant drops grant_valid immediately; no core_start issued.
- free[i] = core_ready[i] & ~reserved[i].
- IDLE: if any thread_req bit and any free bit, in the same cycle:
  - pick thread = first set bit of thread_req at or after the thread pointer (wrapping);
  - pick core = first free bit at or after the core pointer (wrapping);
  - register grant_thread/grant_core, set reserved[core], write owner[core]=thread;
  - pulse thread_ack; go GRANT.
  - Thread pointer := thread+1 mod N_THREADS; core pointer := core+1 mod N_CORES.
  - If no request or no free core, stay IDLE; pointers unchanged.
- GRANT: grant_valid=1 (asserted from the cycle after the IDLE decision).
  - Counter increments each cycle.
  - load_done=1 -> grant_valid=0 next cycle, core_start[grant_core]=1 for exactly one cycle, go IDLE.
  - Counter reaches LOAD_TIMEOUT without load_done -> set load_err, clear reserved[grant_core], no start, go IDLE.
  - load_done in the same cycle as the timeout: load_done wins.
- reserved[i] clears on the first cycle core_ready[i] is sampled low after its start pulse (core has taken ownership); also clears on timeout. A core is never double-granted.
- Grant-to-start latency: minimum 2 cycles (grant in cycle N, load_done at N+1, core_start at N+2). Next grant possible in the cycle after core_start.
- Only one grant is outstanding at a time (single load port).
- load_done outside GRANT is ignored.
- dout_thread = owner[lowest i with core_dout_en[i]]. When no bit is set, it is 0. Owner entries persist until overwritten by the next grant of that core.
- thread_req bits of the currently granted thread are ignored until the state returns to IDLE.

Test Plan:
- Single request: thread_req=8'b0000_0100, all cores ready, load_done 3 cycles after grant -> thread_ack pulse, grant_thread=2, grant_core=0, core_start=3'b001 one cycle after load_done; owner[0]=2; core_ready[0] driven low -> reserved[0] clears.
- Thread fairness: thread_req=8'hFF held, load_done 1 cycle after each grant, cores always ready -> grant_thread sequence 0,1,2,...,7,0; grant_core sequence 0,1,2,0,1,2,...
- Core exhaustion: core_ready=3'b010 only -> grants go only to core 1; second request stays in IDLE with no ack until core_ready[0] or core_ready[2] rises.
- Timeout: grant issued, load_done withheld 64 cycles (LOAD_TIMEOUT=63) -> load_err=1, no core_start, reserved cleared, next request granted to the same core; load_done at exactly cycle 63 instead -> start issued, load_err stays 0.
- Output tagging: threads 5 and 3 granted to cores 0 and 1; core_dout_en=3'b010 -> dout_thread=3; core_dout_en=3'b011 -> dout_thread=5.
- Reset mid-GRANT: RST_N low while grant_valid=1 -> grant_valid, core_start, reserved and pointers all 0 immediately; first grant after release goes to thread 0 / core 0.
